tt_mvex_lq_retire: RTL
======================

// Module: tt_mvex_lq_retire
// PURPOSE
// - In-order retirement buffer downstream of the matrix unit's load-queue result port (mvex_lq*).
// - Issue allocates a tag (lqid) per matrix op. The matrix unit returns results tagged with that lqid, in any order.
// - This block holds each result and releases it strictly in allocation order to the VRF writeback port (valid/ready).
// - Exception flags travel with their entry.
// PARAMETERS
// - LQ_DEPTH_LOG2  3    log2 of entry count; DEPTH = 2**LQ_DEPTH_LOG2; lqid width.
// - VLEN           256  result data width.
// PORTS
// - clk             in   1              clock.
// - reset           in   1              synchronous, active-high reset.
// - i_flush         in   1              discard all entries.
// - i_alloc_vld     in   1              issue requests an entry.
// - i_alloc_vd      in   5              destination vreg for the entry.
// - o_alloc_rdy     out  1              entry available.
// - o_alloc_id      out  LQ_DEPTH_LOG2  lqid granted on alloc handshake.
// - i_mvex_lqvld    in   1              matrix-unit result valid.
// - i_mvex_lqdata   in   VLEN           result data.
// - i_mvex_lqexc    in   1              result exception flag.
// - i_mvex_lqid     in   LQ_DEPTH_LOG2  result tag.
// - o_wb_vld        out  1              head entry ready to write back.
// - i_wb_rdy        in   1              VRF accepts writeback.
// - o_wb_data       out  VLEN           writeback data.
// - o_wb_vd         out  5              writeback destination.
// - o_wb_exc        out  1              writeback exception flag.
// - o_wb_id         out  LQ_DEPTH_LOG2  lqid being retired.
// - o_cpl_err       out  1              1-cycle pulse: result for a non-PEND entry.
// BEHAVIOUR
// - Storage: DEPTH-entry circular buffer.
//   - Per entry: state FREE/PEND/DONE, vd, data, exc.
//   - alloc_ptr and head_ptr are LQ_DEPTH_LOG2+1 bits; the MSB is the wrap bit.
//   - count = alloc_ptr - head_ptr.
// - Reset: all entries FREE, pointers 0, every output 0. o_alloc_rdy rises the cycle after reset deasserts.
// - Alloc:
//   - o_alloc_rdy = (count < DEPTH) && !i_flush. This uses registered count only: no alloc when full, even if a retire happens that cycle.
//   - o_alloc_id = alloc_ptr[LQ_DEPTH_LOG2-1:0].
//   - On vld&&rdy: entry -> PEND, vd captured, alloc_ptr++ (wraps DEPTH-1 -> 0).
// - Completion:
//   - i_mvex_lqvld with target entry PEND: entry -> DONE next cycle; data and exc captured.
//   - Target FREE or DONE: result dropped, o_cpl_err pulses next cycle, no state change.
//   - A completion for the id being allocated in the same cycle is spurious (the entry is still FREE then).
// - Retire:
//   - o_wb_vld = head entry DONE. o_wb_* are driven from the head entry.
//   - Transfer on o_wb_vld && i_wb_rdy: entry -> FREE, head_ptr++.
//   - Outputs hold stable while vld && !rdy.
//   - An exc entry retires like any other; o_wb_exc=1 for it.
//   - Latency: completion in cycle N to o_wb_vld in cycle N+1 (head entry, bypass off).
// - Simultaneous events: alloc, completion and retire in one cycle are independent. They target different entries by construction.
// - Empty: count=0, o_wb_vld=0. Full: count=DEPTH, o_alloc_rdy=0.
// - i_flush:
//   - Same-cycle alloc and completion are ignored. o_wb_vld is forced 0 that cycle.
//   - Next cycle: all entries FREE, pointers 0, o_alloc_rdy=1.
//   - Completions arriving after the flush for old ids pulse o_cpl_err.
// - reset has priority over i_flush.
// CONFIGURATION
// - TT_MVEX_LQ_BYPASS_EN defined:
//   - Condition: i_mvex_lqvld && lqid == head id && head PEND && !i_flush.
//   - Then o_wb_vld=1 the same cycle, with o_wb_data/o_wb_exc taken from i_mvex_lq*. Latency is 0 cycles.
//   - If transferred that cycle, the entry goes FREE. Otherwise it is stored DONE and held next cycle with identical values.
// - Undefined: no bypass; minimum latency is 1 cycle; no combinational path from i_mvex_lq* to o_wb_*.
// TESTING
// - Alloc 3 (vd 1,2,3); complete ids 2,0,1 with data 0xA2/0xA0/0xA1; rdy=1 -> wb order vd1/0xA0, vd2/0xA1, vd3/0xA2.
// - Alloc 8 -> o_alloc_rdy=0. Complete/retire id0 -> rdy=1 next cycle; next alloc grants id0 (wrap).
// - Head DONE, i_wb_rdy=0 for 5 cycles -> o_wb_vld/data/vd stable. Then rdy=1 -> one retire only.
// - Complete id 5 while FREE -> o_cpl_err=1 for one cycle, no wb. Complete id0 with exc=1 -> o_wb_exc=1.
// - 4 PEND, 1 DONE, i_flush=1 -> next cycle count=0, o_wb_vld=0, o_alloc_id=0. Old-id completion -> o_cpl_err.
// - BYPASS_EN: alloc id0, complete id0 with data 0x55 and rdy=1 -> o_wb_vld=1 with 0x55 the same cycle. Without the macro -> next cycle.

Source files
------------

// File: rtl/tt_mvex_lq_retire.sv
// rtl/tt_mvex_lq_retire.sv - in-order retirement buffer for matrix-unit load-queue results
//
// Purpose:
//   Issue allocates an lqid per matrix op. The matrix unit returns results
//   tagged with that lqid in any order. Results are held here and released
//   strictly in allocation order to the VRF writeback port. Each result's
//   exception flag travels with it.
//
// Configuration macro:
//   TT_MVEX_LQ_BYPASS_EN - when defined, a completion that targets the
//   pending head entry is presented on o_wb_* in the same cycle.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   i_flush               discard all entries (next cycle everything FREE)
//   i_alloc_vld/_vd       allocation request and destination vreg
//   o_alloc_rdy/_id       entry available / lqid granted on handshake
//   i_mvex_lq*            matrix-unit result: valid, data, exception, tag
//   o_wb_vld/i_wb_rdy     writeback handshake toward the VRF
//   o_wb_data/_vd/_exc/_id  head entry contents
//   o_cpl_err             1-cycle pulse: result arrived for a non-PEND entry
module tt_mvex_lq_retire #(
  parameter int LQ_DEPTH_LOG2 = 3,
  parameter int VLEN          = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_flush,
  input  logic                     i_alloc_vld,
  input  logic [4:0]               i_alloc_vd,
  output logic                     o_alloc_rdy,
  output logic [LQ_DEPTH_LOG2-1:0] o_alloc_id,
  input  logic                     i_mvex_lqvld,
  input  logic [VLEN-1:0]          i_mvex_lqdata,
  input  logic                     i_mvex_lqexc,
  input  logic [LQ_DEPTH_LOG2-1:0] i_mvex_lqid,
  output logic                     o_wb_vld,
  input  logic                     i_wb_rdy,
  output logic [VLEN-1:0]          o_wb_data,
  output logic [4:0]               o_wb_vd,
  output logic                     o_wb_exc,
  output logic [LQ_DEPTH_LOG2-1:0] o_wb_id,
  output logic                     o_cpl_err
);

  localparam int DEPTH = 1 << LQ_DEPTH_LOG2;
  localparam logic [LQ_DEPTH_LOG2:0] PTR_ONE  = (LQ_DEPTH_LOG2+1)'(1);
  localparam logic [LQ_DEPTH_LOG2:0] PTR_FULL = (LQ_DEPTH_LOG2+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_FREE = 2'd0,
    ST_PEND = 2'd1,
    ST_DONE = 2'd2
  } ent_state_t;

  ent_state_t          st     [DEPTH];
  logic [4:0]          vd_q   [DEPTH];
  logic [VLEN-1:0]     data_q [DEPTH];
  logic                exc_q  [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [LQ_DEPTH_LOG2:0]   alloc_ptr;
  logic [LQ_DEPTH_LOG2:0]   head_ptr;
  logic [LQ_DEPTH_LOG2:0]   count;
  logic [LQ_DEPTH_LOG2-1:0] head_id;
  logic [LQ_DEPTH_LOG2-1:0] alloc_idx;

  logic alloc_fire;
  logic cpl_hit;
  logic cpl_bad;
  logic head_done;
  logic byp;
  logic wb_fire;
  logic cpl_retired;

  assign count     = alloc_ptr - head_ptr;
  assign head_id   = head_ptr[LQ_DEPTH_LOG2-1:0];
  assign alloc_idx = alloc_ptr[LQ_DEPTH_LOG2-1:0];

  // Readiness uses the registered count only, so a same-cycle retire never
  // frees a slot for a same-cycle alloc.
  assign o_alloc_rdy = !reset && (count != PTR_FULL) && !i_flush;
  assign o_alloc_id  = alloc_idx;
  assign alloc_fire  = i_alloc_vld && o_alloc_rdy;

  // An id being allocated this cycle is still FREE, so a completion for it
  // lands in cpl_bad naturally.
  assign cpl_hit = i_mvex_lqvld && !i_flush && (st[i_mvex_lqid] == ST_PEND);
  assign cpl_bad = i_mvex_lqvld && !i_flush && (st[i_mvex_lqid] != ST_PEND);

  assign head_done = (st[head_id] == ST_DONE);

`ifdef TT_MVEX_LQ_BYPASS_EN
  assign byp       = i_mvex_lqvld && (i_mvex_lqid == head_id) &&
                     (st[head_id] == ST_PEND) && !i_flush;
  assign o_wb_data = byp ? i_mvex_lqdata : data_q[head_id];
  assign o_wb_exc  = byp ? i_mvex_lqexc  : exc_q[head_id];
`else
  assign byp       = 1'b0;
  assign o_wb_data = data_q[head_id];
  assign o_wb_exc  = exc_q[head_id];
`endif

  assign o_wb_vld = !reset && !i_flush && (head_done || byp);
  assign o_wb_vd  = vd_q[head_id];
  assign o_wb_id  = head_id;
  assign wb_fire  = o_wb_vld && i_wb_rdy;

  // A bypassed result that retires immediately never needs to be stored.
  assign cpl_retired = byp && i_wb_rdy;

  // Alloc, completion and retire hit distinct entries (FREE / PEND / DONE
  // head), except the bypass case which is resolved through cpl_retired.
  always_ff @(posedge clk) begin
    if (reset) begin
      alloc_ptr <= '0;
      head_ptr  <= '0;
      o_cpl_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        st[i]     <= ST_FREE;
        vd_q[i]   <= '0;
        data_q[i] <= '0;
        exc_q[i]  <= 1'b0;
      end
    end else if (i_flush) begin
      alloc_ptr <= '0;
      head_ptr  <= '0;
      o_cpl_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        st[i] <= ST_FREE;
      end
    end else begin
      o_cpl_err <= cpl_bad;
      if (wb_fire) begin
        st[head_id] <= ST_FREE;
        head_ptr    <= head_ptr + PTR_ONE;
      end
      if (cpl_hit && !cpl_retired) begin
        st[i_mvex_lqid]     <= ST_DONE;
        data_q[i_mvex_lqid] <= i_mvex_lqdata;
        exc_q[i_mvex_lqid]  <= i_mvex_lqexc;
      end
      if (alloc_fire) begin
        st[alloc_idx]   <= ST_PEND;
        vd_q[alloc_idx] <= i_alloc_vd;
        alloc_ptr       <= alloc_ptr + PTR_ONE;
      end
    end
  end

endmodule
